instr_encoder: RTL and testbench

- Streaming RV32I instruction encoder and instruction-memory loader.
- Accepts compact micro-op descriptors (class, register indices, funct3, funct7 bit 5, immediate) over a valid/ready handshake.
- Packs each descriptor into a 32-bit RV32I word and writes it into the instruction memory at sequential word addresses.
- Encode-side counterpart of the control decoder: every class it emits is one the decoder recognises (LOAD, STORE, R, I, BRANCH, JAL). Used for self-test program generation and boot-time loading.

---
 rtl/instr_encoder_if.sv | 51 +++++
 rtl/instr_encoder.sv | 196 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// ============================================================================
//  Module      : instr_encoder_if
//  Description : Descriptor stream, instruction-memory write port and status
//                bundle for instr_encoder. The master drives descriptors and
//                accepts memory writes; the slave is the encoder itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    // Session control and descriptor stream
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_cls;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic              in_f7b5;
    logic [31:0]       in_imm;
    logic              in_last;

    // Instruction-memory write port
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    // Status
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    modport master (
        output start, in_valid, in_cls, in_rd, in_rs1, in_rs2, in_funct3,
               in_f7b5, in_imm, in_last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, count
    );

    modport slave (
        input  start, in_valid, in_cls, in_rd, in_rs1, in_rs2, in_funct3,
               in_f7b5, in_imm, in_last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, count
    );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
//  Module      : instr_encoder
//  Description : Streaming RV32I instruction encoder / instruction-memory
//                loader. Packs micro-op descriptors into 32-bit RV32I words
//                (LOAD, STORE, R, I, BRANCH, JAL) and writes them to
//                sequential word addresses starting at BASE_ADDR.
//                Optional macro ENC_RANGE_CHECK_EN: when defined, immediates
//                and class codes are range-checked; violations emit a NOP
//                and raise the sticky error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  wire logic      clk,
    input  wire logic      rst,     // synchronous, active-low
    instr_encoder_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_addr_max  = '1;
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_cnt_one   = (ADDR_W + 1)'(1);
    localparam logic [31:0]       c_nop       = 32'h0000_0013;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_last;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_count;

    logic [31:0]       w_imm;
    logic [31:0]       w_raw_word;
    logic [31:0]       w_enc_word;
    logic              w_viol;
    logic              w_shift_imm;
    logic              w_unused_imm;

    assign w_imm       = bus.in_imm;
    assign w_shift_imm = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);

    // Upper immediate bits are only consumed by the range check.
    assign w_unused_imm = &{1'b0, w_imm[31:21]};

    // Pack the descriptor into an RV32I word; unused fields stay zero.
    always_comb begin
        w_raw_word = c_nop;
        case (bus.in_cls)
            3'd0: w_raw_word = {w_imm[11:0], bus.in_rs1, bus.in_funct3,
                                bus.in_rd, c_op_load};
            3'd1: w_raw_word = {w_imm[11:5], bus.in_rs2, bus.in_rs1,
                                bus.in_funct3, w_imm[4:0], c_op_store};
            3'd2: w_raw_word = {1'b0, bus.in_f7b5, 5'b00000, bus.in_rs2,
                                bus.in_rs1, bus.in_funct3, bus.in_rd, c_op_r};
            3'd3: begin
                if (w_shift_imm) begin
                    w_raw_word = {1'b0, bus.in_f7b5, 5'b00000, w_imm[4:0],
                                  bus.in_rs1, bus.in_funct3, bus.in_rd, c_op_i};
                end else begin
                    w_raw_word = {w_imm[11:0], bus.in_rs1, bus.in_funct3,
                                  bus.in_rd, c_op_i};
                end
            end
            3'd4: w_raw_word = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1,
                                bus.in_funct3, w_imm[4:1], w_imm[11], c_op_branch};
            3'd5: w_raw_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                                bus.in_rd, c_op_jal};
            default: w_raw_word = c_nop;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic w_imm12_ok;
    logic w_imm13_ok;
    logic w_imm21_ok;

    assign w_imm12_ok = (w_imm[31:11] == {21{w_imm[11]}});
    assign w_imm13_ok = (w_imm[31:12] == {20{w_imm[12]}}) && !w_imm[0];
    assign w_imm21_ok = (w_imm[31:20] == {12{w_imm[20]}}) && !w_imm[0];

    // Flag immediates that do not fit their class, and illegal classes.
    always_comb begin
        w_viol = 1'b0;
        case (bus.in_cls)
            3'd0, 3'd1, 3'd3: w_viol = !w_imm12_ok;
            3'd2:             w_viol = 1'b0;
            3'd4:             w_viol = !w_imm13_ok;
            3'd5:             w_viol = !w_imm21_ok;
            default:          w_viol = 1'b1;
        endcase
    end
`else
    assign w_viol = 1'b0;
`endif

    assign w_enc_word = w_viol ? c_nop : w_raw_word;

    // Session FSM: IDLE -> ACCEPT <-> WRITE -> DONE, all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_addr     <= c_base_addr;
            r_wdata    <= 32'h0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_ACCEPT;
                        r_addr     <= c_base_addr;
                        r_err      <= 1'b0;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_ACCEPT: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_wdata    <= w_enc_word;
                        r_last     <= bus.in_last;
                        r_in_ready <= 1'b0;
                        r_mem_we   <= 1'b1;
                        r_state    <= S_WRITE;
                        if (w_viol) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.mem_ready) begin
                        r_mem_we <= 1'b0;
                        r_addr   <= r_addr + c_addr_one;
                        r_count  <= r_count + c_cnt_one;
                        // Running off the top of memory mid-session is an error.
                        if ((r_addr == c_addr_max) && !r_last) begin
                            r_err <= 1'b1;
                        end
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= S_ACCEPT;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Directed self-checking bench for instr_encoder (ADDR_W=2 so
//                that address wrap is reachable in a few descriptors).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    instr_encoder_if #(.ADDR_W(2)) bus ();

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Present one descriptor, wait for acceptance, then for the write request.
    task automatic send(input logic [2:0] cls, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic f7b5,
                        input logic [31:0] imm, input logic last,
                        output logic [1:0] addr, output logic [31:0] data,
                        output int lat);
        int n;
        @(negedge clk);
        bus.in_cls = cls; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_funct3 = f3; bus.in_f7b5 = f7b5; bus.in_imm = imm;
        bus.in_last = last; bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_checks++; n_fail++;
            $display("FAIL send_accept_timeout: got in_ready=%0b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.mem_we !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) begin
            n_checks++; n_fail++;
            $display("FAIL send_write_timeout: got mem_we=%0b want 1", bus.mem_we);
        end
        addr = bus.mem_addr;
        data = bus.mem_wdata;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %0b want 0", bus.mem_we); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", bus.done); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", bus.err); end
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_checks++; if (bus.mem_addr !== 2'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 00000000", bus.mem_wdata); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start_busy: got %0b want 0", bus.busy); end
    endtask

    task automatic test_r_type();
        logic [1:0] a; logic [31:0] d; int lat;
        do_start();
        send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1, a, d, lat);
        n_checks++; if (d !== 32'h002081B3) begin n_fail++; $display("FAIL add_word: got %h want 002081b3", d); end
        n_checks++; if (a !== 2'd0) begin n_fail++; $display("FAIL add_addr: got %0d want 0", a); end
        n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL add_latency: got %0d want 0", lat); end
        @(negedge clk);
        n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL add_count: got %0d want 1", bus.count); end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %0b want 1", bus.done); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL add_we_drop: got %0b want 0", bus.mem_we); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %0b want 0", bus.done); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_end: got %0b want 0", bus.busy); end
    endtask

    task automatic test_load_store();
        logic [1:0] a; logic [31:0] d; int lat;
        do_start();
        send(3'd0, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 32'd8, 1'b0, a, d, lat);
        n_checks++; if (d !== 32'h00812283) begin n_fail++; $display("FAIL lw_word: got %h want 00812283", d); end
        n_checks++; if (a !== 2'd0) begin n_fail++; $display("FAIL lw_addr: got %0d want 0", a); end
        send(3'd1, 5'd0, 5'd2, 5'd5, 3'd2, 1'b0, 32'd12, 1'b1, a, d, lat);
        n_checks++; if (d !== 32'h00512623) begin n_fail++; $display("FAIL sw_word: got %h want 00512623", d); end
        n_checks++; if (a !== 2'd1) begin n_fail++; $display("FAIL sw_addr: got %0d want 1", a); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ls_done: got %0b want 1", bus.done); end
        n_checks++; if (bus.count !== 3'd2) begin n_fail++; $display("FAIL ls_count: got %0d want 2", bus.count); end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ls_busy: got %0b want 0", bus.busy); end
    endtask

    task automatic test_branch_jal();
        logic [1:0] a; logic [31:0] d; int lat;
        do_start();
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd4, 1'b0, a, d, lat);
        n_checks++; if (d !== 32'hFE208EE3) begin n_fail++; $display("FAIL beq_word: got %h want fe208ee3", d); end
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 1'b1, a, d, lat);
        n_checks++; if (d !== 32'h001000EF) begin n_fail++; $display("FAIL jal_word: got %h want 001000ef", d); end
        n_checks++; if (a !== 2'd1) begin n_fail++; $display("FAIL jal_addr: got %0d want 1", a); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_funct7();
        logic [1:0] a; logic [31:0] d; int lat;
        do_start();
        send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b0, a, d, lat);
        n_checks++; if (d !== 32'h402081B3) begin n_fail++; $display("FAIL sub_word: got %h want 402081b3", d); end
        send(3'd3, 5'd1, 5'd2, 5'd0, 3'd5, 1'b1, 32'd3, 1'b1, a, d, lat);
        n_checks++; if (d !== 32'h40315093) begin n_fail++; $display("FAIL srai_word: got %h want 40315093", d); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall();
        logic [1:0] a; logic [31:0] d; int lat;
        do_start();
        bus.mem_ready = 1'b0;
        send(3'd3, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0, a, d, lat);
        n_checks++; if (d !== 32'h00500093) begin n_fail++; $display("FAIL addi_word: got %h want 00500093", d); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL stall_we[%0d]: got %0b want 1", i, bus.mem_we); end
            n_checks++; if (bus.mem_wdata !== 32'h00500093) begin n_fail++; $display("FAIL stall_wdata[%0d]: got %h want 00500093", i, bus.mem_wdata); end
            n_checks++; if (bus.mem_addr !== 2'd0) begin n_fail++; $display("FAIL stall_addr[%0d]: got %0d want 0", i, bus.mem_addr); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %0b want 0", i, bus.in_ready); end
            n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d want 0", i, bus.count); end
            bus.start = (i == 0);
        end
        bus.start = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL release_we: got %0b want 0", bus.mem_we); end
        n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL release_count: got %0d want 1", bus.count); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %0b want 1", bus.in_ready); end
        send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1, a, d, lat);
        n_checks++; if (a !== 2'd1) begin n_fail++; $display("FAIL start_ignored_addr: got %0d want 1", a); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_range();
        logic [1:0] a; logic [31:0] d; int lat;
        logic [31:0] exp_word;
        logic        exp_err;
`ifdef ENC_RANGE_CHECK_EN
        exp_word = 32'h00000013; exp_err = 1'b1;
`else
        exp_word = 32'h80000013; exp_err = 1'b0;
`endif
        do_start();
        send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h800, 1'b1, a, d, lat);
        n_checks++; if (d !== exp_word) begin n_fail++; $display("FAIL imm800_word: got %h want %h", d, exp_word); end
        n_checks++; if (bus.err !== exp_err) begin n_fail++; $display("FAIL imm800_err: got %0b want %0b", bus.err, exp_err); end
        repeat (2) @(negedge clk);
        n_checks++; if (bus.err !== exp_err) begin n_fail++; $display("FAIL imm800_err_sticky: got %0b want %0b", bus.err, exp_err); end
        do_start();
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL start_clears_err: got %0b want 0", bus.err); end
        send(3'd6, 5'd5, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1, a, d, lat);
        n_checks++; if (d !== 32'h00000013) begin n_fail++; $display("FAIL illegal_word: got %h want 00000013", d); end
        n_checks++; if (bus.err !== exp_err) begin n_fail++; $display("FAIL illegal_err: got %0b want %0b", bus.err, exp_err); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_with_valid();
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_cls = 3'd2; bus.in_rd = 5'd3; bus.in_rs1 = 5'd1; bus.in_rs2 = 5'd2;
        bus.in_funct3 = 3'd0; bus.in_f7b5 = 1'b0; bus.in_imm = 32'd0;
        bus.in_last = 1'b1; bus.in_valid = 1'b1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %0b want 0", bus.in_ready); end
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL start_valid_no_accept: got %0b want 0", bus.mem_we); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL start_valid_ready: got %0b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL start_valid_we: got %0b want 1", bus.mem_we); end
        n_checks++; if (bus.mem_wdata !== 32'h002081B3) begin n_fail++; $display("FAIL start_valid_word: got %h want 002081b3", bus.mem_wdata); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [1:0] a; logic [31:0] d; int lat;
        logic [31:0] exp_word;
        do_start();
        for (int i = 0; i < 5; i++) begin
            send(3'd3, 5'(i + 1), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i), (i == 4), a, d, lat);
            exp_word = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
            n_checks++; if (a !== 2'(i % 4)) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, a, i % 4); end
            n_checks++; if (d !== exp_word) begin n_fail++; $display("FAIL wrap_word[%0d]: got %h want %h", i, d, exp_word); end
            n_checks++; if (bus.err !== (i == 4)) begin n_fail++; $display("FAIL wrap_err[%0d]: got %0b want %0b", i, bus.err, (i == 4)); end
        end
        @(negedge clk);
        n_checks++; if (bus.count !== 3'd5) begin n_fail++; $display("FAIL wrap_count: got %0d want 5", bus.count); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [1:0] a; logic [31:0] d; int lat;
        do_start();
        bus.mem_ready = 1'b0;
        send(3'd3, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0, a, d, lat);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we: got %0b want 0", bus.mem_we); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b want 0", bus.busy); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %0b want 0", bus.in_ready); end
        n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL midrst_wdata: got %h want 00000000", bus.mem_wdata); end
        n_checks++; if (bus.mem_addr !== 2'd0) begin n_fail++; $display("FAIL midrst_addr: got %0d want 0", bus.mem_addr); end
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", bus.count); end
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_stays_idle: got %0b want 0", bus.mem_we); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_cls = 3'd0;
        bus.in_rd = 5'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0;
        bus.in_funct3 = 3'd0; bus.in_f7b5 = 1'b0; bus.in_imm = 32'd0;
        bus.in_last = 1'b0; bus.mem_ready = 1'b1;

        test_reset();
        test_r_type();
        test_load_store();
        test_branch_jal();
        test_funct7();
        test_stall();
        test_range();
        test_start_with_valid();
        test_wrap();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
